// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the multi-port register file
package regfile_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int ZERO_REG     = 0;
endpackage

// File: rtl/regfile_wr_merge.sv
// regfile_wr_merge: priority-merges write ports into per-register enables/data, flags conflicts and zero writes
module regfile_wr_merge
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NW       = 2
) (
    input  logic [NW-1:0]              wr_en,
    input  logic [NW*ADDR_W-1:0]       wr_addr,
    input  logic [NW*DATA_W-1:0]       wr_data,
    output logic [NUM_REGS-1:0]        reg_we,
    output logic [NUM_REGS*DATA_W-1:0] reg_wd,
    output logic                       conflict,
    output logic                       zero_hit
);
    logic [ADDR_W-1:0] a;

    always_comb begin
        reg_we   = '0;
        reg_wd   = '0;
        conflict = 1'b0;
        zero_hit = 1'b0;
        a        = '0;
        for (int p = 0; p < NW; p++) begin
            a = wr_addr[p*ADDR_W +: ADDR_W];
            if (wr_en[p] && a == ADDR_W'(ZERO_REG)) zero_hit = 1'b1;
            else if (wr_en[p]) begin
                conflict                    = conflict | reg_we[a];
                reg_we[a]                   = 1'b1;
                reg_wd[a*DATA_W +: DATA_W]  = wr_data[p*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, busy scoreboard and error flags
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NR       = 4,
    parameter int NW       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR-1:0]        rd_en,
    input  logic [NR*ADDR_W-1:0] rd_addr,
    output logic [NR*DATA_W-1:0] rd_data,
    output logic [NR-1:0]        rd_valid,
    input  logic [NW-1:0]        wr_en,
    input  logic [NW*ADDR_W-1:0] wr_addr,
    input  logic [NW*DATA_W-1:0] wr_data,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 wr_zero_err,
    input  logic                 err_clr,
    output logic                 wr_conflict
);
    logic [NUM_REGS-1:0]        reg_we;
    logic [NUM_REGS*DATA_W-1:0] reg_wd;
    logic                       conflict;
    logic                       zero_hit;
    logic [NUM_REGS-1:0]        busy_n;
    logic [DATA_W-1:0]          mem [NUM_REGS];

    regfile_wr_merge #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NW       (NW)
    ) u_merge (
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .reg_we   (reg_we),
        .reg_wd   (reg_wd),
        .conflict (conflict),
        .zero_hit (zero_hit)
    );

    // mem[0] is only ever reset, so it synthesises to a constant zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (reg_we[i]) mem[i] <= reg_wd[i*DATA_W +: DATA_W];
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] nxt;
        assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
        assign nxt = reg_we[ra] ? reg_wd[ra*DATA_W +: DATA_W] : mem[ra];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_data[k*DATA_W +: DATA_W] <= '0;
            else if (rd_en[k]) rd_data[k*DATA_W +: DATA_W] <= nxt;
        end
    end

    // a reservation outranks a same-edge writeback: the new producer supersedes the old one
    always_comb begin
        busy_n = busy & ~reg_we;
        if (rsv_en) busy_n[rsv_addr] = 1'b1;
        busy_n[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid    <= '0;
            busy        <= '0;
            wr_zero_err <= 1'b0;
            wr_conflict <= 1'b0;
        end else begin
            rd_valid    <= rd_en;
            busy        <= busy_n;
            wr_zero_err <= zero_hit | (wr_zero_err & ~err_clr);
            wr_conflict <= conflict;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with a reference model of storage, scoreboard and flags
module tb_regfile_mp;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   rd_en;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_valid;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         rsv_en;
    logic [4:0]   rsv_addr;
    logic [31:0]  busy;
    logic         wr_zero_err;
    logic         err_clr;
    logic         wr_conflict;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] m [32];
    logic [31:0] rd_m [4];
    logic [3:0]  rv_m;
    logic [31:0] busy_m;
    logic        err_m;
    logic        conf_m;
    int          n_cmp = 0;
    int          n_fail = 0;

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy        (busy),
        .wr_zero_err (wr_zero_err),
        .err_clr     (err_clr),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; err_clr = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_en[k] = 1'b1;
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        for (int k = 0; k < 4; k++) rd_m[k] = '0;
        rv_m = '0; busy_m = '0; err_m = 1'b0; conf_m = 1'b0;
        exp_q.delete();
    endtask

    // advance one clock edge, predicting the DUT state from the inputs applied at that edge
    task automatic tick();
        logic [31:0] nm [32];
        logic        wrote [32];
        logic [31:0] nb;
        logic [4:0]  a;
        logic        ze, cf;
        if (rst) model_reset();
        else begin
            nm = m;
            nb = busy_m;
            ze = 1'b0;
            cf = 1'b0;
            for (int i = 0; i < 32; i++) wrote[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                a = wr_addr[p*5 +: 5];
                if (wr_en[p] && a == 5'd0) ze = 1'b1;
                else if (wr_en[p]) begin
                    if (wrote[a]) cf = 1'b1;
                    wrote[a] = 1'b1;
                    nm[a] = wr_data[p*32 +: 32];
                    nb[a] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 5'd0) nb[rsv_addr] = 1'b1;
            for (int k = 0; k < 4; k++)
                if (rd_en[k]) begin
                    rd_m[k] = nm[rd_addr[k*5 +: 5]];
                    exp_q.push_back('{k, rd_m[k]});
                end
            rv_m = rd_en;
            m = nm;
            busy_m = nb;
            err_m = ze | (err_m & ~err_clr);
            conf_m = cf;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (rd_valid !== '0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_cmp++; if ({wr_zero_err, wr_conflict} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {wr_zero_err, wr_conflict}); end
        rst = 1'b0;
        idle(); set_wr(0, 5, 32'hDEADBEEF); rsv_en = 1'b1; rsv_addr = 5'd6; tick();
        n_cmp++; if (busy !== 32'h0000_0040) begin n_fail++; $display("FAIL pre_reset_busy: got %h want 00000040", busy); end
        idle(); set_rd(0, 5); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== e.data) begin n_fail++; $display("FAIL pre_reset_read p%0d: got %h want %h", e.port, rd_data[e.port*32 +: 32], e.data); end
        end
        rst = 1'b1;
        #2;
        model_reset();
        n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL async_reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL async_reset_busy: got %h want 0", busy); end
        idle(); set_rd(0, 5); tick();
        n_cmp++; if (rd_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_held_valid: got %b want 0000", rd_valid); end
        rst = 1'b0;
        idle(); set_rd(0, 5); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== 32'd0 || e.data !== 32'd0) begin n_fail++; $display("FAIL post_reset_r5 p%0d: got %h want 0", e.port, rd_data[e.port*32 +: 32]); end
        end
        n_cmp++; if (busy !== '0) begin n_fail++; $display("FAIL post_reset_busy: got %h want 0", busy); end
    endtask

    task automatic test_bypass();
        exp_t e;
        idle(); set_wr(0, 7, 32'h12345678); set_rd(0, 7); tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== 32'h12345678) begin n_fail++; $display("FAIL bypass p%0d: got %h want 12345678", e.port, rd_data[e.port*32 +: 32]); end
        end
        n_cmp++; if (rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", rd_valid[0]); end
    endtask

    task automatic test_collision();
        exp_t e;
        idle(); set_wr(0, 3, 32'h1111); set_wr(1, 3, 32'h2222); tick();
        n_cmp++; if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_pulse: got %b want 1", wr_conflict); end
        idle(); set_rd(1, 3); tick();
        n_cmp++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_one_cycle: got %b want 0", wr_conflict); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== 32'h2222) begin n_fail++; $display("FAIL collision_winner p%0d: got %h want 00002222", e.port, rd_data[e.port*32 +: 32]); end
        end
        idle(); set_wr(0, 4, 32'h44); set_wr(1, 8, 32'h88); tick();
        n_cmp++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL no_conflict_distinct: got %b want 0", wr_conflict); end
    endtask

    task automatic test_zero();
        exp_t e;
        idle(); set_wr(1, 0, 32'hFFFFFFFF); set_rd(2, 0); tick();
        n_cmp++; if (wr_zero_err !== 1'b1) begin n_fail++; $display("FAIL zero_err_set: got %b want 1", wr_zero_err); end
        n_cmp++; if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL zero_no_conflict: got %b want 0", wr_conflict); end
        idle(); set_rd(0, 0); tick();
        n_cmp++; if (wr_zero_err !== 1'b1) begin n_fail++; $display("FAIL zero_err_sticky: got %b want 1", wr_zero_err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== 32'd0) begin n_fail++; $display("FAIL r0_read p%0d: got %h want 0", e.port, rd_data[e.port*32 +: 32]); end
        end
        idle(); err_clr = 1'b1; tick();
        n_cmp++; if (wr_zero_err !== 1'b0) begin n_fail++; $display("FAIL zero_err_clr: got %b want 0", wr_zero_err); end
        idle(); wr_data = '1; tick();
        n_cmp++; if (wr_zero_err !== 1'b0) begin n_fail++; $display("FAIL zero_addr_disabled: got %b want 0", wr_zero_err); end
        idle(); set_wr(0, 0, 32'h5); err_clr = 1'b1; tick();
        n_cmp++; if (wr_zero_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set: got %b want 1", wr_zero_err); end
        idle(); err_clr = 1'b1; tick();
        idle(); tick();
    endtask

    task automatic test_scoreboard();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9; tick();
        n_cmp++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL rsv_sets_busy: got %b want 1", busy[9]); end
        idle(); set_wr(1, 9, 32'h99); tick();
        n_cmp++; if (busy[9] !== 1'b0) begin n_fail++; $display("FAIL write_clears_busy: got %b want 0", busy[9]); end
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9; tick();
        idle(); set_wr(0, 9, 32'h999); rsv_en = 1'b1; rsv_addr = 5'd9; tick();
        n_cmp++; if (busy[9] !== 1'b1) begin n_fail++; $display("FAIL rsv_beats_write: got %b want 1", busy[9]); end
        idle(); rsv_en = 1'b1; rsv_addr = 5'd0; tick();
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy0_const: got %b want 0", busy[0]); end
        n_cmp++; if (busy !== busy_m) begin n_fail++; $display("FAIL busy_vector: got %h want %h", busy, busy_m); end
    endtask

    task automatic test_ports();
        exp_t e;
        idle(); set_wr(0, 1, 32'hA1); set_wr(1, 2, 32'hB2); tick();
        idle(); set_wr(0, 31, 32'hC31); tick();
        idle(); set_rd(0, 2); set_rd(1, 31); set_rd(2, 31); set_rd(3, 1); tick();
        exp_q.delete();
        idle();
        rd_addr = {5'd31, 5'd1, 5'd2, 5'd1};
        rd_en = 4'b1010;
        tick();
        n_cmp++; if (rd_valid !== 4'b1010) begin n_fail++; $display("FAIL ports_valid: got %b want 1010", rd_valid); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rd_data[k*32 +: 32] !== rd_m[k]) begin n_fail++; $display("FAIL ports_data p%0d: got %h want %h", k, rd_data[k*32 +: 32], rd_m[k]); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rd_data[e.port*32 +: 32] !== e.data) begin n_fail++; $display("FAIL ports_sb p%0d: got %h want %h", e.port, rd_data[e.port*32 +: 32], e.data); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 2) != 0) set_wr(p, 5'($urandom_range(0, (c % 2) ? 31 : 3)), $urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) != 0) set_rd(k, 5'($urandom_range(0, 31)));
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 31));
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (rd_data[e.port*32 +: 32] !== e.data) begin n_fail++; $display("FAIL rand_read c%0d p%0d: got %h want %h", c, e.port, rd_data[e.port*32 +: 32], e.data); end
            end
            n_cmp++; if (rd_valid !== rv_m) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, rd_valid, rv_m); end
            n_cmp++; if (busy !== busy_m) begin n_fail++; $display("FAIL rand_busy c%0d: got %h want %h", c, busy, busy_m); end
            n_cmp++; if ({wr_zero_err, wr_conflict} !== {err_m, conf_m}) begin n_fail++; $display("FAIL rand_flags c%0d: got %b want %b", c, {wr_zero_err, wr_conflict}, {err_m, conf_m}); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_bypass();
        test_collision();
        test_zero();
        test_scoreboard();
        test_ports();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, the successor to the single-write/dual-read CPU register file.
- Configurable data width, register count, read-port count and write-port count.
- Synchronous registered reads with write-first bypass; hardwired zero register.
- Per-register busy scoreboard for issue stalls, plus sticky and pulse error flags.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the multi-issue core.

Parameters:
- DATA_W, 32: register width in bits.
- NUM_REGS, 32: number of architectural registers; must be a power of two, ≥2.
- ADDR_W, $clog2(NUM_REGS): address width; derived, never overridden.
- NR, 4: number of read ports.
- NW, 2: number of write ports.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  NR  per-port read request.
- rd_addr  in  NR*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NR*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W].
- rd_valid  out  NR  high one cycle after the matching rd_en.
- wr_en  in  NW  per-port write enable.
- wr_addr  in  NW*ADDR_W  write addresses.
- wr_data  in  NW*DATA_W  write data.
- rsv_en  in  1  reserve (mark busy) the destination register of an issued instruction.
- rsv_addr  in  ADDR_W  register to reserve.
- busy  out  NUM_REGS  scoreboard; bit i set means register i has a pending writer.
- wr_zero_err  out  1  sticky flag; set when any wr_en targets address 0.
- err_clr  in  1  clears wr_zero_err.
- wr_conflict  out  1  one-cycle pulse when two enabled write ports hit the same nonzero address.

Behaviour:
- Reset (async, rst=1):
  - All registers = 0; rd_data = 0; rd_valid = 0; busy = 0; wr_zero_err = 0; wr_conflict = 0.
  - Reset asserted mid-operation discards all in-flight writes, reservations and reads immediately.
- Register 0:
  - Always reads 0; never stored.
  - Writes to address 0 are dropped and set wr_zero_err. Unlike the previous generation, only an enabled write sets the flag; wr_en=0 with wr_addr=0 has no effect.
  - rsv_en to address 0 is ignored; busy[0] is constant 0.
- Writes (posedge):
  - Each port with wr_en=1 and nonzero address updates its register.
  - Same address on several ports: the highest-index port wins, and wr_conflict = 1 for exactly the following cycle.
- Reads (latency 1):
  - At a posedge where rd_en[k]=1, rd_data[k] captures the register value after that same edge's writes (write-first bypass, highest writer wins).
  - rd_valid[k] = rd_en[k] delayed one cycle.
  - rd_en[k]=0: rd_data[k] holds its previous value.
- Scoreboard, per register i≠0, at posedge:
  - Cleared if any wr_en port writes i.
  - Set if rsv_en and rsv_addr=i.
  - Set and clear on the same edge: set wins, because the new producer supersedes the old one.
  - busy changes become visible the cycle after the edge.
- err_clr and a new zero-write on the same edge: the flag stays set.
- No combinational paths from inputs to outputs; all outputs are registered, and busy is a direct register output.

Decomposition:
- Shared package regfile_pkg: default DATA_W/NUM_REGS constants and the ZERO_REG address constant.
- One sub-module, regfile_wr_merge: combinational priority resolution of the NW write ports into a per-register write-enable and data vector, plus conflict detect.
- The top instantiates regfile_wr_merge and uses its outputs for both storage update and read bypass.

Test Plan:
- Reset check: assert rst mid-stream after writing r5=0xDEADBEEF; read r5 -> rd_data 0 and busy all 0 while rst is high and after release.
- Bypass: same cycle wr port0 r7=0x12345678 and rd_en[0] r7 -> next cycle rd_data[0]=0x12345678, rd_valid[0]=1.
- Write collision: wr port0 r3=0x1111, port1 r3=0x2222 -> r3 reads 0x2222; wr_conflict pulses 1 for one cycle only.
- Zero register: wr_en port1 r0=0xFFFFFFFF -> read r0 = 0 and wr_zero_err=1 (sticky); pulse err_clr -> 0. Then wr_en=0 with wr_addr=0 -> flag stays 0.
- Scoreboard:
  - rsv r9 -> busy[9]=1 next cycle; write r9 -> busy[9]=0.
  - rsv r9 and write r9 on the same edge -> busy[9] stays 1.
  - rsv r0 -> busy[0] stays 0.
- Read-port independence: NR=4 ports read r1,r2,r1,r31 with only rd_en=4'b1010 -> ports 1 and 3 update; ports 0 and 2 hold their previous values with rd_valid=0.
